seg_scan_decoder: RTL
=====================

# seg_scan_decoder

Receive-side counterpart of the hex-to-seven-segment encoder. The block monitors a multiplexed seven-segment display bus (segment lines plus one-hot digit select) and qualifies each digit on stability. It decodes each segment pattern back to a hex nibble and decimal point, and emits a complete frame once every digit has been seen. It serves as a display-bus checker and loopback receiver in the display subsystem.

## Interface
- `NUM_DIGITS`, 4: number of multiplexed digits (1–8).
- `STABLE_CYCLES`, 4: consecutive identical samples required to accept a digit (≥2).
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `seg_in` input 8: segment bus, active-high lit, bit order {dp,g,f,e,d,c,b,a}.
- `an_in` input NUM_DIGITS: digit select, active-high, one-hot when driving.
- `digit_valid` output 1: one-cycle pulse, a digit was accepted.
- `digit_idx` output 3: index of the accepted digit.
- `digit_hex` output 4: decoded nibble of the accepted digit (0 if invalid).
- `digit_err` output 1: accepted pattern is not one of the 16 legal codes.
- `frame_valid` output 1: one-cycle pulse, all digits captured.
- `hex_out` output 4*NUM_DIGITS: frame nibbles, digit i at [4i+3:4i].
- `dp_out` output NUM_DIGITS: frame decimal points.
- `frame_err` output 1: OR of per-digit error bits for the emitted frame.

## Operation
- Legal codes, gfedcba: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - dp (bit 7) is independent of the code.
  - A blank (00) or any other pattern decodes to nibble 0 with err=1.
- Input sampling: `seg_in` and `an_in` are registered every cycle into `s_seg` and `s_an`. The block compares only the registered values.
- FSM states:
  - IDLE: `s_an` is not one-hot (zero or multiple bits). Counter is 0 and no capture occurs. Exit to SETTLE when `s_an` is one-hot.
  - SETTLE: the counter increments each cycle that (`s_seg`,`s_an`) equals the previous sample. On any change, the counter is cleared: go to SETTLE if the new `s_an` is one-hot, else IDLE. When the count reaches STABLE_CYCLES−1, capture and go to HELD.
  - HELD: the digit is already accepted and no re-capture occurs. On any change of (`s_seg`,`s_an`), go to SETTLE or IDLE as above.
- Capture actions:
  - Pulse `digit_valid` and drive `digit_idx`, `digit_hex`, `digit_err`.
  - Write the nibble, dp and err into buffer slot `digit_idx`.
  - Set `seen[digit_idx]`.
- Re-capture of an already-seen digit before the frame completes: the slot is overwritten and `seen` is unchanged.
- Frame: when `seen` becomes all-ones, then on the next cycle:
  - pulse `frame_valid`;
  - load `hex_out`, `dp_out` and `frame_err` from the buffer;
  - clear `seen`.
- Frame outputs hold until the next frame.
- A capture in the same cycle as the `seen` clear starts the new frame. Its `seen` bit is set, not lost.
- Counter width is $clog2(STABLE_CYCLES). Saturation is not needed because HELD stops counting.

## Timing
- Reset values:
  - all outputs are 0;
  - FSM is in IDLE;
  - `seen`, the buffer and the counter are 0.
- Reset is asynchronous mid-operation. A partial frame is discarded and no pulse is emitted.
- Digit latency: inputs constant from edge k, sampled into `s_*` at edge k. `digit_valid` is high during the cycle after edge k+STABLE_CYCLES.
- `frame_valid` occurs exactly 1 cycle after the completing `digit_valid`.
- `digit_valid` pulses at most once per stable (`an`,`seg`) interval.
- Minimum digit dwell for acceptance is STABLE_CYCLES+1 cycles including the input register.
- `an_in` with `digit_idx` ≥ NUM_DIGITS cannot occur, because the width matches NUM_DIGITS.

## Structure
- `seg_scan_pkg` contains:
  - the 16 segment-code localparams;
  - the FSM state enum (IDLE/SETTLE/HELD);
  - the `onehot_idx` function.
- Sub-module `seg7_to_hex`: combinational {7-bit pattern} → {nibble, err}. It is reusable by other display checkers.
- The top level holds the input registers, FSM, counter, buffer and frame logic.

## Test plan
- Reset then scan, with N=4 and S=4:
  - stimulus: an=0001/0010/0100/1000 with patterns 3F, 06, 5B, 4F, each held 8 cycles;
  - response: four `digit_valid` pulses, then `frame_valid` with `hex_out`=16'h3210, `dp_out`=0, `frame_err`=0.
- dp and invalid code:
  - stimulus: digit 2 driven with seg=8'hFF, then digit 1 with seg=8'h00;
  - response: digit 2 gives nibble 8 with dp=1; digit 1 gives `digit_err`=1; the frame has `frame_err`=1.
- Glitch rejection:
  - stimulus: digit 0 held 3 cycles, changed, then held 5 cycles;
  - response: exactly one `digit_valid`, carrying the second value.
- Non-one-hot handling:
  - stimulus: an=0000 and an=0011 held 20 cycles;
  - response: no `digit_valid`, and `seen` unchanged.
- Overwrite and reset:
  - stimulus: digit 0 captured as 1, then re-captured as 7 before the frame completes;
  - response: `hex_out`[3:0]=7.
  - stimulus: `rst_n` asserted after 3 of 4 digits;
  - response: all outputs 0, and the next frame needs all 4 digits.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared segment codes, FSM states and one-hot helpers
package seg_scan_pkg;

  // Legal seven-segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } state_t;

  // True when exactly one bit of v is set
  function automatic logic is_onehot(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

  // Index of the set bit of a one-hot vector (highest set bit otherwise)
  function automatic logic [2:0] onehot_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// rtl/seg7_to_hex.sv - combinational seven-segment pattern to hex nibble decoder
module seg7_to_hex
  import seg_scan_pkg::*;
(
  input  logic [6:0] seg_pat,
  output logic [3:0] hex,
  output logic       err
);

  // Map each legal pattern to its nibble; anything else is 0 with err set
  always_comb begin
    hex = 4'h0;
    err = 1'b0;
    case (seg_pat)
      SEG_0:   hex = 4'h0;
      SEG_1:   hex = 4'h1;
      SEG_2:   hex = 4'h2;
      SEG_3:   hex = 4'h3;
      SEG_4:   hex = 4'h4;
      SEG_5:   hex = 4'h5;
      SEG_6:   hex = 4'h6;
      SEG_7:   hex = 4'h7;
      SEG_8:   hex = 4'h8;
      SEG_9:   hex = 4'h9;
      SEG_A:   hex = 4'hA;
      SEG_B:   hex = 4'hB;
      SEG_C:   hex = 4'hC;
      SEG_D:   hex = 4'hD;
      SEG_E:   hex = 4'hE;
      SEG_F:   hex = 4'hF;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - multiplexed seven-segment bus receiver with frame assembly
module seg_scan_decoder
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  output logic                    digit_valid,
  output logic [2:0]              digit_idx,
  output logic [3:0]              digit_hex,
  output logic                    digit_err,
  output logic                    frame_valid,
  output logic [4*NUM_DIGITS-1:0] hex_out,
  output logic [NUM_DIGITS-1:0]   dp_out,
  output logic                    frame_err
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  // Capture fires on the cycle the count would reach STABLE_CYCLES-1
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 2);

  logic [7:0]              s_seg_q, s_seg_d, p_seg_q, p_seg_d;
  logic [NUM_DIGITS-1:0]   s_an_q, s_an_d, p_an_q, p_an_d;
  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic [4*NUM_DIGITS-1:0] hex_buf_q, hex_buf_d;
  logic [NUM_DIGITS-1:0]   dp_buf_q, dp_buf_d;
  logic [NUM_DIGITS-1:0]   err_buf_q, err_buf_d;
  logic                    digit_valid_q, digit_valid_d;
  logic [2:0]              digit_idx_q, digit_idx_d;
  logic [3:0]              digit_hex_q, digit_hex_d;
  logic                    digit_err_q, digit_err_d;
  logic                    frame_valid_q, frame_valid_d;
  logic [4*NUM_DIGITS-1:0] hex_out_q, hex_out_d;
  logic [NUM_DIGITS-1:0]   dp_out_q, dp_out_d;
  logic                    frame_err_q, frame_err_d;

  logic       same;
  logic       an_ok;
  logic       capture;
  logic       seen_full;
  logic [7:0] an_ext;
  logic [3:0] dec_hex;
  logic       dec_err;

  seg7_to_hex u_dec (
    .seg_pat (s_seg_q[6:0]),
    .hex     (dec_hex),
    .err     (dec_err)
  );

  assign an_ext    = 8'(s_an_q);
  assign an_ok     = is_onehot(an_ext);
  assign same      = (s_seg_q == p_seg_q) && (s_an_q == p_an_q);
  assign seen_full = &seen_q;

  // Stability FSM: count matching samples, capture once per stable interval
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (an_ok) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!same) begin
          cnt_d   = '0;
          state_d = an_ok ? ST_SETTLE : ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          capture = 1'b1;
          state_d = ST_HELD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HELD: begin
        if (!same) begin
          cnt_d   = '0;
          state_d = an_ok ? ST_SETTLE : ST_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Input sampling, digit reporting, slot buffer and frame emission
  always_comb begin
    s_seg_d       = seg_in;
    s_an_d        = an_in;
    p_seg_d       = s_seg_q;
    p_an_d        = s_an_q;
    digit_valid_d = capture;
    digit_idx_d   = digit_idx_q;
    digit_hex_d   = digit_hex_q;
    digit_err_d   = digit_err_q;
    hex_buf_d     = hex_buf_q;
    dp_buf_d      = dp_buf_q;
    err_buf_d     = err_buf_q;
    // A capture landing on the clear cycle seeds the next frame
    seen_d        = seen_full ? '0 : seen_q;
    frame_valid_d = seen_full;
    hex_out_d     = seen_full ? hex_buf_q : hex_out_q;
    dp_out_d      = seen_full ? dp_buf_q : dp_out_q;
    frame_err_d   = seen_full ? (|err_buf_q) : frame_err_q;
    if (capture) begin
      digit_idx_d = onehot_idx(an_ext);
      digit_hex_d = dec_hex;
      digit_err_d = dec_err;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (s_an_q[i]) begin
          hex_buf_d[4*i +: 4] = dec_hex;
          dp_buf_d[i]         = s_seg_q[7];
          err_buf_d[i]        = dec_err;
          seen_d[i]           = 1'b1;
        end
      end
    end
  end

  // State register with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_seg_q       <= '0;
      s_an_q        <= '0;
      p_seg_q       <= '0;
      p_an_q        <= '0;
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      seen_q        <= '0;
      hex_buf_q     <= '0;
      dp_buf_q      <= '0;
      err_buf_q     <= '0;
      digit_valid_q <= 1'b0;
      digit_idx_q   <= '0;
      digit_hex_q   <= '0;
      digit_err_q   <= 1'b0;
      frame_valid_q <= 1'b0;
      hex_out_q     <= '0;
      dp_out_q      <= '0;
      frame_err_q   <= 1'b0;
    end else begin
      s_seg_q       <= s_seg_d;
      s_an_q        <= s_an_d;
      p_seg_q       <= p_seg_d;
      p_an_q        <= p_an_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      seen_q        <= seen_d;
      hex_buf_q     <= hex_buf_d;
      dp_buf_q      <= dp_buf_d;
      err_buf_q     <= err_buf_d;
      digit_valid_q <= digit_valid_d;
      digit_idx_q   <= digit_idx_d;
      digit_hex_q   <= digit_hex_d;
      digit_err_q   <= digit_err_d;
      frame_valid_q <= frame_valid_d;
      hex_out_q     <= hex_out_d;
      dp_out_q      <= dp_out_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign digit_valid = digit_valid_q;
  assign digit_idx   = digit_idx_q;
  assign digit_hex   = digit_hex_q;
  assign digit_err   = digit_err_q;
  assign frame_valid = frame_valid_q;
  assign hex_out     = hex_out_q;
  assign dp_out      = dp_out_q;
  assign frame_err   = frame_err_q;

endmodule
